// File: rtl/snn_ff_pkg.sv
// Shared widths, request encodings and scheduler state encoding for the
// neuron event scheduler.
package snn_ff_pkg;

  localparam int N_NEUR_DEF = 256;
  localparam int CORE_W     = 12;
  localparam int CNT_W      = 7;
  localparam int WGT_W      = 8;
  localparam int ADDR_W     = 8;
  localparam int ST_W       = CNT_W + CORE_W;
  localparam int SYN_AW     = 2 * ADDR_W;

  typedef enum logic [1:0] {
    REQ_SYN   = 2'd0,
    REQ_TSTEP = 2'd1,
    REQ_TREF  = 2'd2,
    REQ_ILL   = 2'd3
  } req_type_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2
  } sched_state_e;

endpackage

// File: rtl/neuron_event_sched_if.sv
// Sweep-request handshake and output spike stream of the neuron event scheduler.
interface neuron_event_sched_if;
  import snn_ff_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_type;
  logic [ADDR_W-1:0] req_pre_addr;

  logic              spk_valid;
  logic              spk_ready;
  logic [ADDR_W-1:0] spk_addr;

  modport slave (
    input  req_valid, req_type, req_pre_addr, spk_ready,
    output req_ready, spk_valid, spk_addr
  );

  modport master (
    output req_valid, req_type, req_pre_addr, spk_ready,
    input  req_ready, spk_valid, spk_addr
  );
endinterface

// File: rtl/neur_spk_fifo.sv
// Synchronous FIFO for spiking neuron addresses, with an occupancy count
// used by the scheduler for back-pressure.
module neur_spk_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;

endmodule

// File: rtl/neuron_event_sched.sv
// Sweeps all post-synaptic neurons for one request: read state (and weight),
// hand it to the neuron datapath, write the result back, queue output spikes.
module neuron_event_sched
  import snn_ff_pkg::*;
#(
  parameter int N_NEUR    = N_NEUR_DEF,
  parameter int SPK_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  neuron_event_sched_if.slave      sif,
  output logic                     syn_rd_en,
  output logic [SYN_AW-1:0]        syn_rd_addr,
  input  logic signed [WGT_W-1:0]  syn_rd_data,
  output logic                     st_rd_en,
  output logic [ADDR_W-1:0]        st_rd_addr,
  input  logic [ST_W-1:0]          st_rd_data,
  output logic                     st_wr_en,
  output logic [ADDR_W-1:0]        st_wr_addr,
  output logic [ST_W-1:0]          st_wr_data,
  output logic signed [CORE_W-1:0] nrn_state_core,
  output logic [CNT_W-1:0]         nrn_post_spike_cnt,
  output logic signed [WGT_W-1:0]  nrn_syn_weight,
  output logic                     nrn_neuron_event,
  output logic                     nrn_time_step_event,
  output logic                     nrn_time_ref_event,
  input  logic signed [CORE_W-1:0] nrn_state_core_next,
  input  logic [CNT_W-1:0]         nrn_post_spike_cnt_next,
  input  logic                     nrn_spike_out,
  output logic                     done
);

  localparam int                CW       = $clog2(SPK_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEUR - 1);
  localparam logic [CW:0]       FULL_OCC = (CW + 1)'(SPK_DEPTH);

  sched_state_e      state_q, state_d;
  req_type_e         type_q;
  logic [ADDR_W-1:0] pre_q;
  logic [ADDR_W-1:0] idx_q;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;

  logic              accept, issue, stall, req_ready_c;
  logic              syn_issue, push, pop, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occ;
  logic [ADDR_W-1:0] fifo_dout;

  assign accept = (state_q == S_IDLE) && sif.req_valid;

  // Count the stage-1 entry as already occupying a slot, so a push is never dropped.
  assign occ   = {1'b0, fifo_count} + {{CW{1'b0}}, vld_p1};
  assign stall = (type_q == REQ_TSTEP) && (occ >= FULL_OCC);

  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    done        = 1'b0;
    req_ready_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_c = 1'b1;
        if (sif.req_valid)
          state_d = (req_type_e'(sif.req_type) == REQ_ILL) ? S_DRAIN : S_SWEEP;
      end
      S_SWEEP: begin
        issue = !stall;
        if (!stall && (idx_q == LAST_IDX)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      type_q  <= REQ_SYN;
      idx_q   <= '0;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= issue;
      if (accept) begin
        type_q <= req_type_e'(sif.req_type);
        idx_q  <= '0;
      end else if (issue) begin
        idx_q  <= idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pre_q <= sif.req_pre_addr;
    addr_p1 <= idx_q;
  end

  // Stage 0: SRAM read issue
  assign syn_issue   = issue && (type_q == REQ_SYN);
  assign st_rd_en    = issue;
  assign st_rd_addr  = issue ? idx_q : '0;
  assign syn_rd_en   = syn_issue;
  assign syn_rd_addr = syn_issue ? {pre_q, idx_q} : '0;

  // Stage 1: datapath drive, write-back, spike push
  assign nrn_state_core      = vld_p1 ? $signed(st_rd_data[CORE_W-1:0]) : '0;
  assign nrn_post_spike_cnt  = vld_p1 ? st_rd_data[ST_W-1:CORE_W] : '0;
  assign nrn_syn_weight      = (vld_p1 && (type_q == REQ_SYN)) ? syn_rd_data : '0;
  assign nrn_neuron_event    = vld_p1 && (type_q == REQ_SYN);
  assign nrn_time_step_event = vld_p1 && (type_q == REQ_TSTEP);
  assign nrn_time_ref_event  = vld_p1 && (type_q == REQ_TREF);

  assign st_wr_en   = vld_p1;
  assign st_wr_addr = vld_p1 ? addr_p1 : '0;
  assign st_wr_data = vld_p1 ? {nrn_post_spike_cnt_next, nrn_state_core_next} : '0;

  assign push = vld_p1 && (type_q == REQ_TSTEP) && nrn_spike_out;
  assign pop  = !fifo_empty && sif.spk_ready;

  neur_spk_fifo #(
    .DEPTH (SPK_DEPTH),
    .W     (ADDR_W)
  ) u_spk_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (addr_p1),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign sif.req_ready = req_ready_c;
  assign sif.spk_valid = !fifo_empty;
  assign sif.spk_addr  = fifo_empty ? '0 : fifo_dout;

endmodule
